// File: rtl/jump_ctrl.sv
// rtl/jump_ctrl.sv - jump game flow FSM, charge/flight counters and score; JUMP_DEBOUNCE_EN adds a button debouncer
module jump_ctrl #(
    parameter int CHARGE_TICK = 250000,
    parameter int CHARGE_MAX  = 200,
    parameter int FLIGHT_TICK = 125000,
    parameter int DEB_CYCLES  = 250000
) (
    input  logic       clk_machine,
    input  logic       rst_machine,
    input  logic       btn_jump,
    input  logic       land_hit,
    output logic [2:0] state,
    output logic [7:0] charge,
    output logic [7:0] jump_len,
    output logic [7:0] jump_step,
    output logic       jump_start,
    output logic [7:0] score
);
    localparam int TICK_W  = $clog2(CHARGE_TICK + 1);
    localparam int FTICK_W = $clog2(FLIGHT_TICK + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STAND  = 3'd1,
        S_SETTLE = 3'd2,
        S_ACCU   = 3'd3,
        S_JUMP   = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_sync;
    logic                w_btn_lvl;
    logic                r_lvl_d;
    logic                r_rise;
    logic                r_fall;
    logic [TICK_W-1:0]   r_tick;
    logic [TICK_W-1:0]   w_tick_nxt;
    logic [FTICK_W-1:0]  r_ftick;
    logic [FTICK_W-1:0]  w_ftick_nxt;
    logic [7:0]          r_charge;
    logic [7:0]          w_charge_nxt;
    logic [7:0]          w_charge_inc;
    logic [7:0]          r_len;
    logic [7:0]          w_len_nxt;
    logic [7:0]          r_step;
    logic [7:0]          w_step_nxt;
    logic [7:0]          r_score;
    logic [7:0]          w_score_nxt;
    logic                r_start;
    logic                w_start_nxt;
    logic                w_tick_wrap;
    logic                w_ftick_wrap;

    always_ff @(posedge clk_machine) begin
        if (!rst_machine) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], btn_jump};
        end
    end

`ifdef JUMP_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic [DEB_W-1:0] r_deb_cnt;
    logic             r_deb_lvl;

    // Level follows the synchronized input only after it has disagreed for DEB_CYCLES samples in a row.
    always_ff @(posedge clk_machine) begin
        if (!rst_machine) begin
            r_deb_cnt <= '0;
            r_deb_lvl <= 1'b0;
        end else if (r_sync[1] == r_deb_lvl) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            r_deb_cnt <= '0;
            r_deb_lvl <= r_sync[1];
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    assign w_btn_lvl = r_deb_lvl;
`else
    assign w_btn_lvl = r_sync[1];
`endif

    always_ff @(posedge clk_machine) begin
        if (!rst_machine) begin
            r_lvl_d <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_lvl_d <= w_btn_lvl;
            r_rise  <= w_btn_lvl & ~r_lvl_d;
            r_fall  <= ~w_btn_lvl & r_lvl_d;
        end
    end

    assign w_tick_wrap  = (r_tick == TICK_W'(CHARGE_TICK - 1));
    assign w_ftick_wrap = (r_ftick == FTICK_W'(FLIGHT_TICK - 1));
    // Charge including this cycle's increment, so a release on the saturating tick still latches the max.
    assign w_charge_inc = !w_tick_wrap ? r_charge :
                          (r_charge >= 8'(CHARGE_MAX)) ? 8'(CHARGE_MAX) : r_charge + 8'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_tick_nxt   = r_tick;
        w_ftick_nxt  = r_ftick;
        w_charge_nxt = r_charge;
        w_len_nxt    = r_len;
        w_step_nxt   = r_step;
        w_score_nxt  = r_score;
        w_start_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_rise) begin
                    w_state_nxt = S_STAND;
                    w_score_nxt = 8'd0;
                end
            end
            S_STAND: begin
                if (r_rise) begin
                    w_state_nxt  = S_ACCU;
                    w_charge_nxt = 8'd0;
                    w_tick_nxt   = '0;
                end
            end
            S_ACCU: begin
                w_tick_nxt = w_tick_wrap ? '0 : r_tick + 1'b1;
                if (r_fall) begin
                    w_state_nxt  = S_JUMP;
                    w_len_nxt    = (w_charge_inc == 8'd0) ? 8'd1 : w_charge_inc;
                    w_step_nxt   = 8'd0;
                    w_ftick_nxt  = '0;
                    w_start_nxt  = 1'b1;
                    w_charge_nxt = 8'd0;
                end else begin
                    w_charge_nxt = w_charge_inc;
                end
            end
            S_JUMP: begin
                if (w_ftick_wrap) begin
                    w_ftick_nxt = '0;
                    w_step_nxt  = r_step + 8'd1;
                    if (r_step + 8'd1 == r_len) begin
                        w_state_nxt = S_SETTLE;
                    end
                end else begin
                    w_ftick_nxt = r_ftick + 1'b1;
                end
            end
            S_SETTLE: begin
                if (land_hit) begin
                    w_state_nxt = S_STAND;
                    w_score_nxt = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                end else begin
                    w_state_nxt = S_OVER;
                end
            end
            S_OVER: begin
                if (r_rise) begin
                    w_state_nxt = S_STAND;
                    w_score_nxt = 8'd0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_machine) begin
        if (!rst_machine) begin
            r_state  <= S_IDLE;
            r_tick   <= '0;
            r_ftick  <= '0;
            r_charge <= 8'd0;
            r_len    <= 8'd0;
            r_step   <= 8'd0;
            r_score  <= 8'd0;
            r_start  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tick   <= w_tick_nxt;
            r_ftick  <= w_ftick_nxt;
            r_charge <= w_charge_nxt;
            r_len    <= w_len_nxt;
            r_step   <= w_step_nxt;
            r_score  <= w_score_nxt;
            r_start  <= w_start_nxt;
        end
    end

    assign state      = r_state;
    assign charge     = r_charge;
    assign jump_len   = r_len;
    assign jump_step  = r_step;
    assign jump_start = r_start;
    assign score      = r_score;
endmodule

// File: tb/tb_jump_ctrl.sv
// tb/tb_jump_ctrl.sv - self-checking bench for jump_ctrl (honours JUMP_DEBOUNCE_EN)
module tb_jump_ctrl;
    localparam int CT   = 4;
    localparam int FT   = 2;
    localparam int DEB  = 3;
    localparam int CMAX = 5;
`ifdef JUMP_DEBOUNCE_EN
    localparam int LAT    = DEB + 4;
    localparam bit DEB_ON = 1'b1;
`else
    localparam int LAT    = 4;
    localparam bit DEB_ON = 1'b0;
`endif

    logic       clk_machine = 1'b0;
    logic       rst_machine;
    logic       btn_jump;
    logic       land_hit;
    logic [2:0] state;
    logic [7:0] charge;
    logic [7:0] jump_len;
    logic [7:0] jump_step;
    logic       jump_start;
    logic [7:0] score;

    jump_ctrl #(
        .CHARGE_TICK(CT),
        .CHARGE_MAX (CMAX),
        .FLIGHT_TICK(FT),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk_machine(clk_machine),
        .rst_machine(rst_machine),
        .btn_jump   (btn_jump),
        .land_hit   (land_hit),
        .state      (state),
        .charge     (charge),
        .jump_len   (jump_len),
        .jump_step  (jump_step),
        .jump_start (jump_start),
        .score      (score)
    );

    always #5 clk_machine = ~clk_machine;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: button level from pin history, game rules from elapsed-cycle arithmetic.
    bit pins[$];
    bit sh[$];
    bit lq[$];
    bit m_lvl;
    int m_state, m_charge, m_len, m_step, m_start, m_score, m_accu, m_flight;

    typedef struct {
        int hold;
        bit land;
        int exp_len;
        int exp_maxc;
        int exp_state;
        int exp_score;
    } row_t;
    row_t rows[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input bit p, input bit l, input bit rn);
        bit s1, lv, rise, fall, all_diff, bit_w;
        int n, c, idx;
        m_start = 0;
        if (!rn) begin
            pins.delete(); sh.delete(); lq.delete();
            m_lvl = 1'b0; m_state = 0; m_charge = 0; m_len = 0; m_step = 0; m_score = 0;
            return;
        end
        pins.push_back(p);
        n  = pins.size();
        s1 = (n >= 2) ? pins[n-2] : 1'b0;
        if (DEB_ON) begin
            all_diff = 1'b1;
            for (int j = 1; j <= DEB; j++) begin
                idx   = sh.size() - j;
                bit_w = (idx >= 0) ? sh[idx] : 1'b0;
                if (bit_w == m_lvl) all_diff = 1'b0;
            end
            if (all_diff) m_lvl = ~m_lvl;
            lv = m_lvl;
        end else begin
            lv = s1;
        end
        sh.push_back(s1);
        lq.push_back(lv);
        n    = lq.size();
        rise = ((n >= 3) ? lq[n-3] : 1'b0) & ~((n >= 4) ? lq[n-4] : 1'b0);
        fall = ~((n >= 3) ? lq[n-3] : 1'b0) & ((n >= 4) ? lq[n-4] : 1'b0);
        if (pins.size() > 16) begin
            void'(pins.pop_front()); void'(sh.pop_front()); void'(lq.pop_front());
        end
        case (m_state)
            0: if (rise) begin m_state = 1; m_score = 0; end
            1: if (rise) begin m_state = 3; m_accu = 0; m_charge = 0; end
            3: begin
                m_accu++;
                c = m_accu / CT;
                if (c > CMAX) c = CMAX;
                if (fall) begin
                    m_len = (c < 1) ? 1 : c;
                    m_step = 0; m_start = 1; m_charge = 0; m_flight = 0; m_state = 4;
                end else begin
                    m_charge = c;
                end
            end
            4: begin
                m_flight++;
                m_step = m_flight / FT;
                if (m_step == m_len) m_state = 2;
            end
            2: begin
                if (l) begin
                    m_state = 1;
                    if (m_score < 255) m_score++;
                end else begin
                    m_state = 5;
                end
            end
            5: if (rise) begin m_state = 1; m_score = 0; end
            default: m_state = 0;
        endcase
    endtask

    task automatic step(input bit p, input bit l, input bit rn);
        btn_jump    = p;
        land_hit    = l;
        rst_machine = rn;
        @(posedge clk_machine);
        #1;
        model_step(p, l, rn);
        chk("m_state", int'(state), m_state);
        chk("m_charge", int'(charge), m_charge);
        chk("m_jump_len", int'(jump_len), m_len);
        chk("m_jump_step", int'(jump_step), m_step);
        chk("m_jump_start", int'(jump_start), m_start);
        chk("m_score", int'(score), m_score);
        cyc++;
    endtask

    task automatic run_jump(input int hold, input bit land, output int flight,
                            output int starts, output int maxc, output bit done);
        int seen4, seen2;
        seen4 = -1; seen2 = -1; starts = 0; maxc = 0; done = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step(1'b1, land, 1'b1);
            if (int'(charge) > maxc) maxc = int'(charge);
        end
        for (int t = 0; t < 300 && !done; t++) begin
            step(1'b0, land, 1'b1);
            if (int'(charge) > maxc) maxc = int'(charge);
            if (jump_start) starts++;
            if (state == 3'd4 && seen4 < 0) seen4 = t;
            if (state == 3'd2 && seen2 < 0) seen2 = t;
            if (seen2 >= 0 && state != 3'd2) done = 1'b1;
        end
        flight = seen2 - seen4;
    endtask

    task automatic press_until(input int target, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            step(1'b1, 1'b0, 1'b1);
            if (int'(state) == target) hit = 1'b1;
        end
        if (!hit) chk(name, int'(state), target);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        int flight, starts, maxc, cnt;
        bit done, seen_accu, seen_jump, moved;
        int glen;

        rows[0] = '{hold: 14, land: 1'b1, exp_len: 3, exp_maxc: 3, exp_state: 1, exp_score: 1};
        rows[1] = '{hold: 40, land: 1'b1, exp_len: 5, exp_maxc: 5, exp_state: 1, exp_score: 2};
        rows[2] = '{hold: 3,  land: 1'b1, exp_len: 1, exp_maxc: 0, exp_state: 1, exp_score: 3};
        rows[3] = '{hold: 8,  land: 1'b1, exp_len: 2, exp_maxc: 1, exp_state: 1, exp_score: 4};
        rows[4] = '{hold: 3,  land: 1'b0, exp_len: 1, exp_maxc: 0, exp_state: 5, exp_score: 4};

        rst_machine = 1'b0; btn_jump = 1'b0; land_hit = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        chk("reset_state", int'(state), 0);
        chk("reset_score", int'(score), 0);

        // Clean press: IDLE -> STAND after LAT cycles; holding must not start ACCU.
        cnt = 0; done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            step(1'b1, 1'b0, 1'b1);
            cnt++;
            if (state == 3'd1) done = 1'b1;
        end
        chk("press_latency", cnt, LAT);
        chk("press_score", int'(score), 0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1);
        chk("held_no_accu", int'(state), 1);
        idle(LAT + 2);

        for (int r = 0; r < 5; r++) begin
            run_jump(rows[r].hold, rows[r].land, flight, starts, maxc, done);
            chk("row_done", int'(done), 1);
            chk("row_jump_len", int'(jump_len), rows[r].exp_len);
            chk("row_max_charge", maxc, rows[r].exp_maxc);
            chk("row_flight", flight, rows[r].exp_len * FT);
            chk("row_start_pulses", starts, 1);
            chk("row_state", int'(state), rows[r].exp_state);
            chk("row_score", int'(score), rows[r].exp_score);
            idle(LAT + 2);
        end

        press_until(1, "over_to_stand");
        chk("over_score_clr", int'(score), 0);
        idle(LAT + 2);

        for (int k = 0; k < 256; k++) begin
            run_jump(3, 1'b1, flight, starts, maxc, done);
            if (!done) chk("preload_done", int'(done), 1);
            idle(LAT + 1);
        end
        chk("score_saturate", int'(score), 255);

        // Reset while charging.
        press_until(3, "reach_accu");
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("rst_accu_state", int'(state), 0);
        chk("rst_accu_charge", int'(charge), 0);
        chk("rst_accu_start", int'(jump_start), 0);
        idle(LAT + 2);

        // Reset in flight.
        press_until(1, "reach_stand");
        idle(LAT + 2);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (state == 3'd4) done = 1'b1;
        end
        chk("reach_jump", int'(done), 1);
        step(1'b0, 1'b0, 1'b0);
        chk("rst_jump_state", int'(state), 0);
        chk("rst_jump_len", int'(jump_len), 0);
        chk("rst_jump_step", int'(jump_step), 0);
        chk("rst_jump_start", int'(jump_start), 0);
        chk("rst_jump_score", int'(score), 0);
        idle(2);

        // Two-cycle glitch in STAND.
        press_until(1, "glitch_stand");
        idle(LAT + 2);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        seen_accu = 1'b0; seen_jump = 1'b0; moved = 1'b0; glen = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (state != 3'd1) moved = 1'b1;
            if (state == 3'd3) seen_accu = 1'b1;
            if (state == 3'd4 && !seen_jump) begin seen_jump = 1'b1; glen = int'(jump_len); end
        end
        if (DEB_ON) begin
            chk("glitch_filtered", int'(moved), 0);
        end else begin
            chk("glitch_accu", int'(seen_accu), 1);
            chk("glitch_jump", int'(seen_jump), 1);
            chk("glitch_len", glen, 1);
        end

        // Randomized runs against the model.
        for (int r = 0; r < 400; r++) begin
            bit p, l, rn;
            int len;
            p   = 1'($urandom_range(0, 1));
            l   = 1'($urandom_range(0, 1));
            rn  = ($urandom_range(0, 99) != 0);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 8);
            for (int i = 0; i < len; i++) step(p, l, (i == 0) ? rn : 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
